regf_wb_sched: RTL and testbench

Write-back scheduler and scoreboard for the integer register file. Shares the register file's single write port between three producers (ALU, load unit, multi-cycle ext unit) via round-robin arbitration with valid/ready handshakes, and drives the registered write port one cycle after grant. Tracks per-register pending-write busy bits so the decode stage can stall on RAW/WAW hazards against the registered-read register file.

---
 rtl/regf_pkg.sv | 13 +
 rtl/rr_arb3.sv | 32 +++
 rtl/regf_wb_sched.sv | 99 +++++++++
 tb/tb_regf_wb_sched.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/regf_pkg.sv
// Shared constants and types for the integer register-file write-back scheduler.
package regf_pkg;
  localparam int NUM_REQ = 3;
  localparam int XLEN    = 32;
  localparam int REQ_ALU = 0;
  localparam int REQ_MEM = 1;
  localparam int REQ_EXT = 2;

  typedef struct packed {
    logic [4:0]      addr;
    logic [XLEN-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/rr_arb3.sv
// Combinational 3-way round-robin arbiter: first valid requester at or after ptr_i wins.
module rr_arb3 (
  input  logic [2:0] valid_i,
  input  logic [1:0] ptr_i,
  output logic [2:0] grant_o,
  output logic [1:0] ptr_nxt_o,
  output logic       any_o
);

  function automatic logic [1:0] wrap3(input logic [2:0] v);
    logic [2:0] t;
    t = (v >= 3'd3) ? (v - 3'd3) : v;
    return t[1:0];
  endfunction

  always_comb begin
    logic [1:0] idx;
    grant_o   = '0;
    ptr_nxt_o = ptr_i;
    any_o     = 1'b0;
    idx       = '0;
    for (int k = 0; k < 3; k++) begin
      idx = wrap3({1'b0, ptr_i} + 3'(k));
      if (!any_o && valid_i[idx]) begin
        grant_o[idx] = 1'b1;
        ptr_nxt_o    = (idx == 2'd2) ? 2'd0 : (idx + 2'd1);
        any_o        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regf_wb_sched.sv
// Write-back scheduler: arbitrates three producers onto the registered register-file
// write port and keeps per-register pending-write busy bits for decode hazard checks.
module regf_wb_sched
  import regf_pkg::*;
(
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0][4:0]       req_addr,
  input  logic [NUM_REQ-1:0][XLEN-1:0]  req_data,
  output logic                          w_enable,
  output logic [4:0]                    w_addr,
  output logic [XLEN-1:0]               w_data,
  input  logic                          issue_valid,
  input  logic [4:0]                    issue_rd,
  input  logic [4:0]                    q_rs1,
  input  logic [4:0]                    q_rs2,
  input  logic [4:0]                    q_rd,
  output logic                          busy_rs1,
  output logic                          busy_rs2,
  output logic                          busy_rd
);

  logic [NUM_REQ-1:0] valid_gated;
  logic [NUM_REQ-1:0] grant;
  logic [1:0]         ptr_nxt;
  logic               any_grant;
  wb_req_t            sel;

  logic [1:0]         rr_ptr_q,  rr_ptr_d;
  logic               w_en_q,    w_en_d;
  logic [4:0]         w_addr_q,  w_addr_d;
  logic [XLEN-1:0]    w_data_q,  w_data_d;
  logic [31:0]        busy_q,    busy_d;

  // No grants while held in reset, so producers never see a spurious accept.
  assign valid_gated = req_valid & {NUM_REQ{rstn}};

  rr_arb3 u_arb (
    .valid_i   (valid_gated),
    .ptr_i     (rr_ptr_q),
    .grant_o   (grant),
    .ptr_nxt_o (ptr_nxt),
    .any_o     (any_grant)
  );

  assign req_ready = grant;

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel.addr = req_addr[i];
        sel.data = req_data[i];
      end
    end
  end

  always_comb begin
    rr_ptr_d = any_grant ? ptr_nxt : rr_ptr_q;
    w_en_d   = any_grant && (sel.addr != 5'd0);
    w_addr_d = any_grant ? sel.addr : w_addr_q;
    w_data_d = any_grant ? sel.data : w_data_q;

    // Clear first so a same-edge issue to the committing register keeps it busy.
    busy_d = busy_q;
    if (w_en_q)
      busy_d[w_addr_q] = 1'b0;
    if (issue_valid && (issue_rd != 5'd0))
      busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rr_ptr_q <= '0;
      w_en_q   <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
      busy_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      w_en_q   <= w_en_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
      busy_q   <= busy_d;
    end
  end

  assign w_enable = w_en_q;
  assign w_addr   = w_addr_q;
  assign w_data   = w_data_q;

  assign busy_rs1 = busy_q[q_rs1];
  assign busy_rs2 = busy_q[q_rs2];
  assign busy_rd  = busy_q[q_rd];

endmodule

// File: tb/tb_regf_wb_sched.sv
// Scoreboard bench for regf_wb_sched: grants, write-port contents and busy bits
// are predicted by a reference model and compared every cycle.
module tb_regf_wb_sched;

  logic              clk = 1'b0;
  logic              rstn;
  logic [2:0]        req_valid;
  logic [2:0]        req_ready;
  logic [2:0][4:0]   req_addr;
  logic [2:0][31:0]  req_data;
  logic              w_enable;
  logic [4:0]        w_addr;
  logic [31:0]       w_data;
  logic              issue_valid;
  logic [4:0]        issue_rd;
  logic [4:0]        q_rs1, q_rs2, q_rd;
  logic              busy_rs1, busy_rs2, busy_rd;

  typedef struct packed {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_wr_t;

  exp_wr_t     exp_q[$];
  logic [1:0]  m_ptr;
  logic [31:0] m_busy;
  logic        stream;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  regf_wb_sched dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .w_enable    (w_enable),
    .w_addr      (w_addr),
    .w_data      (w_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .q_rs1       (q_rs1),
    .q_rs2       (q_rs2),
    .q_rd        (q_rd),
    .busy_rs1    (busy_rs1),
    .busy_rs2    (busy_rs2),
    .busy_rd     (busy_rd)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: check outputs at the falling edge, advance the model at the rising edge.
  task automatic step();
    exp_wr_t    c;
    logic       cen;
    logic [4:0] caddr;
    logic [2:0] eg;
    logic [1:0] np;
    int         idx;
    @(negedge clk);
    cen   = 1'b0;
    caddr = '0;
    if (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      chk("w_enable", {31'd0, w_enable}, {31'd0, c.en});
      chk("w_addr",   {27'd0, w_addr},   {27'd0, c.addr});
      chk("w_data",   w_data,            c.data);
      cen   = c.en;
      caddr = c.addr;
    end else begin
      chk("w_enable_idle", {31'd0, w_enable}, 32'd0);
    end
    chk("busy_rs1", {31'd0, busy_rs1}, {31'd0, m_busy[q_rs1]});
    chk("busy_rs2", {31'd0, busy_rs2}, {31'd0, m_busy[q_rs2]});
    chk("busy_rd",  {31'd0, busy_rd},  {31'd0, m_busy[q_rd]});

    eg = '0;
    np = m_ptr;
    if (rstn === 1'b1) begin
      for (int k = 0; k < 3; k++) begin
        idx = (int'(m_ptr) + k) % 3;
        if (eg == 3'b000 && req_valid[idx]) begin
          eg[idx] = 1'b1;
          np      = 2'((idx + 1) % 3);
          exp_q.push_back('{en: (req_addr[idx] != 5'd0), addr: req_addr[idx], data: req_data[idx]});
        end
      end
    end
    chk("req_ready", {29'd0, req_ready}, {29'd0, eg});

    @(posedge clk);
    if (rstn !== 1'b1) begin
      m_ptr  = 2'd0;
      m_busy = '0;
      exp_q.delete();
    end else begin
      m_ptr = np;
      if (cen) m_busy[caddr] = 1'b0;
      if (issue_valid && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
      m_busy[0] = 1'b0;
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      if (eg[i]) begin
        if (stream) req_data[i] = req_data[i] + 32'd1;
        else        req_valid[i] = 1'b0;
      end
    end
  endtask

  initial begin
    m_ptr       = 2'd0;
    m_busy      = '0;
    stream      = 1'b0;
    rstn        = 1'b0;
    req_valid   = 3'b111;
    req_addr    = '{5'd3, 5'd2, 5'd1};
    req_data    = '{32'h3, 32'h2, 32'h1};
    issue_valid = 1'b0;
    issue_rd    = '0;
    q_rs1       = 5'd1;
    q_rs2       = 5'd2;
    q_rd        = 5'd3;

    // Reset held two cycles with every producer requesting.
    step();
    step();
    rstn      = 1'b1;
    req_valid = 3'b000;
    step();

    // Single ALU write to x5 after issuing x5.
    q_rd        = 5'd5;
    issue_valid = 1'b1;
    issue_rd    = 5'd5;
    step();
    issue_valid = 1'b0;
    req_addr[0] = 5'd5;
    req_data[0] = 32'hDEADBEEF;
    req_valid   = 3'b001;
    step();
    step();
    step();

    // Round robin from a freshly reset pointer.
    rstn = 1'b0;
    step();
    rstn      = 1'b1;
    stream    = 1'b1;
    req_addr  = '{5'd13, 5'd12, 5'd11};
    req_data  = '{32'hC000_0000, 32'hB000_0000, 32'hA000_0000};
    req_valid = 3'b111;
    for (int n = 0; n < 6; n++) step();
    stream    = 1'b0;
    req_valid = 3'b000;
    step();

    // Write to x0 is accepted but never strobes the register file.
    q_rs1       = 5'd0;
    req_addr[1] = 5'd0;
    req_data[1] = 32'h1234;
    req_valid   = 3'b010;
    step();
    step();
    step();

    // Set and clear of x7 collide on the same edge.
    q_rd        = 5'd7;
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    step();
    issue_valid = 1'b0;
    req_addr[0] = 5'd7;
    req_data[0] = 32'h0707_0707;
    req_valid   = 3'b001;
    step();
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    step();
    issue_valid = 1'b0;
    step();
    chk("busy7_after_collision", {31'd0, busy_rd}, 32'd1);

    // Reset lands while an EXT write sits on the write port.
    q_rd        = 5'd9;
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    req_addr[2] = 5'd12;
    req_data[2] = 32'hE0E0_E0E0;
    req_valid   = 3'b100;
    step();
    issue_valid = 1'b0;
    rstn        = 1'b0;
    step();
    rstn      = 1'b1;
    req_addr  = '{5'd3, 5'd2, 5'd1};
    req_data  = '{32'h33, 32'h22, 32'h11};
    req_valid = 3'b111;
    step();
    req_valid = 3'b000;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
